// File: rtl/hash_arb_pkg.sv
// Shared types and default sizing for the hash-table request arbiter.
package hash_arb_pkg;

    localparam int unsigned DEF_NUM_REQ         = 4;
    localparam int unsigned DEF_KEY_WIDTH       = 5;
    localparam int unsigned DEF_DATA_WIDTH      = 25;
    localparam int unsigned DEF_RSP_WIDTH       = 64;
    localparam int unsigned DEF_MAX_OUTSTANDING = 8;

    localparam int unsigned REQ_ID_W  = $clog2(DEF_NUM_REQ);
    localparam int unsigned DEF_REQ_W = 2 + DEF_KEY_WIDTH + DEF_DATA_WIDTH;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OP_DELETE = 2'b00,
        OP_WRITE  = 2'b01,
        OP_READ   = 2'b10
    } hash_op_e;

    // Request beat layout as seen by the hash table: {op, key, data}
    typedef struct packed {
        logic [1:0]                op;
        logic [DEF_KEY_WIDTH-1:0]  key;
        logic [DEF_DATA_WIDTH-1:0] data;
    } req_beat_t;

endpackage

// File: rtl/hash_request_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for accepted beats awaiting their results.
module id_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only read while count is non-zero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/hash_request_arbiter.sv
// Round-robin, burst-locking arbiter sharing one hash-table stream among
// NUM_REQ requesters, with in-order routing of results back to their owners.
module hash_request_arbiter
    import hash_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ          = DEF_NUM_REQ,
    parameter int unsigned KEY_WIDTH        = DEF_KEY_WIDTH,
    parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int unsigned RSP_WIDTH        = DEF_RSP_WIDTH,
    parameter int unsigned MAX_OUTSTANDING  = DEF_MAX_OUTSTANDING,
    localparam int unsigned REQ_WIDTH       = 2 + DATA_WIDTH + KEY_WIDTH,
    localparam int unsigned ID_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned IDX_W           = ID_W + 1,
    localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ*REQ_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic [REQ_WIDTH-1:0]         tbl_data_o,
    output logic                         tbl_valid_o,
    output logic                         tbl_last_o,
    input  logic                         tbl_ready_i,
    input  logic [RSP_WIDTH-1:0]         tbl_rsp_data_i,
    input  logic                         tbl_rsp_valid_i,
    output logic                         tbl_rsp_ready_o,
    output logic [RSP_WIDTH-1:0]         rsp_data_o,
    output logic [NUM_REQ-1:0]           rsp_valid_o,
    input  logic [NUM_REQ-1:0]           rsp_ready_i,
    output logic [CNT_W-1:0]             outstanding_o,
    output logic                         orphan_rsp_o
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             orphan_q, orphan_d;

    logic             grant_vld_c;
    logic [ID_W-1:0]  grant_id_c;
    logic [IDX_W-1:0] cand_c;
    logic             accept_c;
    logic             pop_c;

    logic             fifo_full;
    logic             fifo_empty;
    logic [ID_W-1:0]  fifo_head;
    logic [CNT_W-1:0] fifo_count;

    // Grant: burst owner while locked, else first valid requester from rr_ptr upward
    always_comb begin
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        cand_c      = '0;
        if (state_q == LOCKED) begin
            grant_vld_c = 1'b1;
            grant_id_c  = owner_q;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cand_c = IDX_W'(rr_ptr_q) + IDX_W'(i);
                if (cand_c >= IDX_W'(NUM_REQ)) begin
                    cand_c = cand_c - IDX_W'(NUM_REQ);
                end
                if (!grant_vld_c && req_valid_i[cand_c[ID_W-1:0]]) begin
                    grant_vld_c = 1'b1;
                    grant_id_c  = cand_c[ID_W-1:0];
                end
            end
        end
    end

    // Request mux: zero-latency pass-through of the granted requester
    always_comb begin
        req_ready_o = '0;
        tbl_data_o  = '0;
        tbl_last_o  = 1'b0;
        tbl_valid_o = 1'b0;
        if (!reset && grant_vld_c) begin
            tbl_data_o              = req_data_i[grant_id_c*REQ_WIDTH +: REQ_WIDTH];
            tbl_last_o              = req_last_i[grant_id_c];
            tbl_valid_o             = req_valid_i[grant_id_c] && !fifo_full;
            req_ready_o[grant_id_c] = tbl_ready_i && !fifo_full;
        end
    end

    assign accept_c = tbl_valid_o && tbl_ready_i;

    // Response demux: head of the ID FIFO owns the current result beat
    always_comb begin
        rsp_valid_o     = '0;
        tbl_rsp_ready_o = 1'b0;
        pop_c           = 1'b0;
        if (!reset) begin
            if (fifo_empty) begin
                tbl_rsp_ready_o = 1'b1;
            end else begin
                rsp_valid_o[fifo_head] = tbl_rsp_valid_i;
                tbl_rsp_ready_o        = rsp_ready_i[fifo_head];
                pop_c                  = tbl_rsp_valid_i && rsp_ready_i[fifo_head];
            end
        end
    end

    assign rsp_data_o    = tbl_rsp_data_i;
    assign outstanding_o = fifo_count;
    assign orphan_rsp_o  = orphan_q;

    // Next state: lock on a non-last beat, rotate priority past the owner on the last
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        orphan_d = orphan_q || (tbl_rsp_valid_i && fifo_empty);
        if (accept_c) begin
            if (tbl_last_o) begin
                state_d  = IDLE;
                rr_ptr_d = (grant_id_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_c + ID_W'(1);
            end else begin
                state_d = LOCKED;
                owner_d = grant_id_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            orphan_q <= orphan_d;
        end
    end

    id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (accept_c),
        .push_data_i (grant_id_c),
        .pop_i       (pop_c),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule
